// File: rtl/fmul_rr_arbiter_if.sv
// Bundle of every signal the fmul_rr_arbiter touches except clock and reset.
//
// Modports:
//   slave  - the arbiter: takes requests, the response-ready and the multiplier
//            result/status; drives grants, the response channel, the
//            multiplier start/operands and arb_busy.
//   master - the surrounding system (requesters, response consumer and the
//            multiplier itself).
//
// Signals:
//   req_valid/req_ready     per-requester handshake, one bit each
//   req_rs1/req_rs2         packed operands, slice i belongs to requester i
//   rsp_valid/rsp_ready     shared response handshake
//   rsp_id/rsp_result/rsp_err  response payload
//   mul_start/mul_rs1/mul_rs2  multiplier launch
//   mul_result/mul_valid/mul_busy  multiplier completion and status
//   arb_busy                arbiter not idle
interface fmul_rr_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_rs1;
    logic [NUM_REQ*32-1:0] req_rs2;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_result;
    logic                  rsp_err;
    logic                  mul_start;
    logic [31:0]           mul_rs1;
    logic [31:0]           mul_rs2;
    logic [31:0]           mul_result;
    logic                  mul_valid;
    logic                  mul_busy;
    logic                  arb_busy;

    modport slave (
        input  req_valid, req_rs1, req_rs2, rsp_ready, mul_result, mul_valid, mul_busy,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, mul_start, mul_rs1,
               mul_rs2, arb_busy
    );

    modport master (
        output req_valid, req_rs1, req_rs2, rsp_ready, mul_result, mul_valid, mul_busy,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, mul_start, mul_rs1,
               mul_rs2, arb_busy
    );
endinterface

// File: rtl/fmul_rr_arbiter.sv
// Round-robin arbiter sharing one IEEE 754 single-precision multiplier among
// NUM_REQ requesters. One operation is in flight at a time:
// IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset (0 = reset)
//   bus   fmul_rr_arbiter_if.slave: request ports, response channel and the
//         multiplier start/busy/valid interface
//
// Optional feature: define FMUL_ARB_TIMEOUT_EN to enable a WAIT-state watchdog.
// After TIMEOUT_CYCLES cycles in WAIT without mul_valid, the arbiter responds
// with rsp_err = 1 and a quiet NaN result. Without the macro WAIT lasts until
// mul_valid and rsp_err is tied low.
module fmul_rr_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ID_W           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic              clk,
    input logic              rst,
    fmul_rr_arbiter_if.slave bus
);

    // Internal index width is the minimum needed; rsp_id is zero-extended.
    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned SumW = IdxW + 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || (2 ** ID_W) < NUM_REQ || TIMEOUT_CYCLES == 0)
    begin : g_bad_params
        $error("fmul_rr_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]   id_q, id_d;
    logic [31:0]       op_a_q, op_a_d;
    logic [31:0]       op_b_q, op_b_d;
    logic [31:0]       res_q, res_d;

`ifdef FMUL_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] QNaN = 32'h7FC0_0000;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              err_q, err_d;
`endif

    // Grant search
    logic              gnt_found;
    logic [IdxW-1:0]   gnt_idx;
    logic [31:0]       gnt_a, gnt_b;
    logic [SumW-1:0]   scan_sum;
    logic [IdxW-1:0]   scan_idx;
    logic              xfer;
    logic [NUM_REQ-1:0] ready;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_a     = '0;
        gnt_b     = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_sum = SumW'(rr_ptr_q) + SumW'(k);
            if (scan_sum >= SumW'(NUM_REQ)) begin
                scan_sum = scan_sum - SumW'(NUM_REQ);
            end
            scan_idx = scan_sum[IdxW-1:0];
            if (!gnt_found && bus.req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
                gnt_a     = bus.req_rs1[{scan_idx, 5'b0} +: 32];
                gnt_b     = bus.req_rs2[{scan_idx, 5'b0} +: 32];
            end
        end
    end

    // Grant is gated by rst so every output reads zero while reset is held.
    always_comb begin
        ready = '0;
        if (rst && state_q == StIdle && !bus.mul_busy && gnt_found) begin
            ready[gnt_idx] = 1'b1;
        end
    end

    assign xfer = (state_q == StIdle) && !bus.mul_busy && gnt_found;

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        res_d    = res_q;
`ifdef FMUL_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    id_d    = gnt_idx;
                    op_a_d  = gnt_a;
                    op_b_d  = gnt_b;
                    state_d = StIssue;
                end
            end
            StIssue: begin
`ifdef FMUL_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = StWait;
            end
            StWait: begin
                if (bus.mul_valid) begin
                    res_d   = bus.mul_result;
`ifdef FMUL_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = StResp;
                end
`ifdef FMUL_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    res_d   = QNaN;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rr_ptr_d = (id_q == IdxW'(NUM_REQ - 1)) ? '0 : id_q + IdxW'(1);
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
`ifdef FMUL_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
`ifdef FMUL_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.req_ready  = ready;
    assign bus.mul_start  = (state_q == StIssue);
    assign bus.mul_rs1    = op_a_q;
    assign bus.mul_rs2    = op_b_q;
    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_id     = ID_W'(id_q);
    assign bus.rsp_result = res_q;
    assign bus.arb_busy   = (state_q != StIdle);
`ifdef FMUL_ARB_TIMEOUT_EN
    assign bus.rsp_err    = err_q;
`else
    assign bus.rsp_err    = 1'b0;
`endif

endmodule
